parity_initiator: RTL and testbench

Initiator end of the byte-parity test link. It sends a pseudo-random AXI-Stream packet to the parity-responder and checks the reply:
- odd total parity expects a single 0xFF beat;
- even total parity expects the three beats 0xAB, 0x12, 0xDE.

It reports pass/fail per packet and keeps running packet and error counts for the test harness.

---
 rtl/parity_initiator_if.sv | 25 ++
 rtl/parity_initiator.sv | 138 +++++++++++++
 tb/tb_parity_initiator.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_initiator_if.sv
// rtl/parity_initiator_if.sv - packet (m) and response (s) AXI-Stream channels of the parity link
interface parity_initiator_if;
    logic       axis_m_tvalid;
    logic [7:0] axis_m_tdata;
    logic       axis_m_tready;
    logic       axis_m_tlast;
    logic       axis_s_tvalid;
    logic [7:0] axis_s_tdata;
    logic       axis_s_tready;
    logic       axis_s_tlast;

    modport master (
        output axis_m_tvalid, axis_m_tdata, axis_m_tlast,
        input  axis_m_tready,
        input  axis_s_tvalid, axis_s_tdata, axis_s_tlast,
        output axis_s_tready
    );

    modport slave (
        input  axis_m_tvalid, axis_m_tdata, axis_m_tlast,
        output axis_m_tready,
        output axis_s_tvalid, axis_s_tdata, axis_s_tlast,
        input  axis_s_tready
    );
endinterface

// File: rtl/parity_initiator.sv
// rtl/parity_initiator.sv - byte-parity link initiator: sends an LFSR packet and checks the parity reply
module parity_initiator #(
    parameter int         PKT_LEN   = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         TIMEOUT   = 255
) (
    input  logic               a_clk,
    input  logic               axis_areset,
    input  logic               start,
    parity_initiator_if.master axis,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        pkt_count,
    output logic [15:0]        err_count
);
    localparam logic [7:0]  SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0]  LAST_IDX = 8'(PKT_LEN - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SEND, RECV, DRAIN, FIN} state_t;
    state_t state, state_nx;

    logic [7:0]  lfsr;
    logic [7:0]  idx;
    logic        parity;
    logic        exp_odd;
    logic [1:0]  ridx;
    logic [15:0] tcnt;
    logic        m_hs, s_hs;
    logic [7:0]  exp_byte;
    logic        exp_last;
    logic        beat_ok;
    logic        fin_pass;
    logic        tmo_hit;

    assign m_hs    = (state == SEND) && axis.axis_m_tready;
    assign s_hs    = ((state == RECV) || (state == DRAIN)) && axis.axis_s_tvalid;
    assign tmo_hit = (tcnt == TMO_LAST);

    // Reply pattern: odd parity -> FF(last); even parity -> AB, 12, DE(last)
    always_comb begin
        exp_byte = 8'hFF;
        exp_last = 1'b1;
        if (!exp_odd) begin
            case (ridx)
                2'd0:    begin exp_byte = 8'hAB; exp_last = 1'b0; end
                2'd1:    begin exp_byte = 8'h12; exp_last = 1'b0; end
                default: begin exp_byte = 8'hDE; exp_last = 1'b1; end
            endcase
        end
    end

    assign beat_ok = (axis.axis_s_tdata == exp_byte) && (axis.axis_s_tlast == exp_last);

    always_ff @(posedge a_clk) begin
        if (axis_areset) state <= IDLE;
        else             state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        fin_pass = 1'b0;
        case (state)
            IDLE: if (start) state_nx = SEND;
            SEND: if (m_hs && (idx == LAST_IDX)) state_nx = RECV;
            RECV: begin
                if (s_hs) begin
                    if (beat_ok && exp_last) begin
                        state_nx = FIN;
                        fin_pass = 1'b1;
                    end else if (!beat_ok) begin
                        state_nx = axis.axis_s_tlast ? FIN : DRAIN;
                    end
                end else if (tmo_hit) begin
                    state_nx = FIN;
                end
            end
            DRAIN: begin
                if (s_hs) begin
                    if (axis.axis_s_tlast) state_nx = FIN;
                end else if (tmo_hit) begin
                    state_nx = FIN;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (axis_areset) begin
            lfsr      <= SEED;
            idx       <= '0;
            parity    <= 1'b0;
            exp_odd   <= 1'b0;
            ridx      <= '0;
            tcnt      <= '0;
            pass      <= 1'b0;
            pkt_count <= '0;
            err_count <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                idx    <= '0;
                parity <= 1'b0;
            end
            if (m_hs) begin
                lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                parity <= parity ^ (^lfsr);
                idx    <= idx + 8'd1;
                if (idx == LAST_IDX) begin
                    exp_odd <= parity ^ (^lfsr);
                    ridx    <= '0;
                    tcnt    <= '0;
                end
            end
            // Idle counter restarts on every accepted response beat
            if (s_hs) begin
                tcnt <= '0;
                if ((state == RECV) && beat_ok) ridx <= ridx + 2'd1;
            end else if ((state == RECV) || (state == DRAIN)) begin
                tcnt <= tcnt + 16'd1;
            end
            if (state_nx == FIN) begin
                pass      <= fin_pass;
                pkt_count <= pkt_count + 16'd1;
                if (!fin_pass) err_count <= err_count + 16'd1;
            end
        end
    end

    assign axis.axis_m_tvalid = (state == SEND);
    assign axis.axis_m_tdata  = (state == SEND) ? lfsr : 8'h00;
    assign axis.axis_m_tlast  = (state == SEND) && (idx == LAST_IDX);
    assign axis.axis_s_tready = (state == RECV) || (state == DRAIN);
    assign busy               = (state != IDLE);
    assign done               = (state == FIN);
endmodule

// File: tb/tb_parity_initiator.sv
// tb/tb_parity_initiator.sv - randomized bench for parity_initiator against a queue-based link model
module tb_parity_initiator;
    localparam int PKT_LEN = 4;
    localparam int TMO     = 10;

    logic        a_clk       = 1'b0;
    logic        axis_areset = 1'b1;
    logic        start       = 1'b0;
    logic        busy, done, pass;
    logic [15:0] pkt_count, err_count;

    parity_initiator_if axis ();

    parity_initiator #(
        .PKT_LEN   (PKT_LEN),
        .LFSR_SEED (8'hA5),
        .TIMEOUT   (TMO)
    ) dut (
        .a_clk       (a_clk),
        .axis_areset (axis_areset),
        .start       (start),
        .axis        (axis),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .pkt_count   (pkt_count),
        .err_count   (err_count)
    );

    always #5 a_clk = ~a_clk;

    typedef enum {M_IDLE, M_SEND, M_RSP, M_FIN} phase_t;
    phase_t     ph = M_IDLE;
    logic [7:0] m_lfsr = 8'hA5;
    logic [7:0] tx_q[$];
    logic [8:0] want_q[$];
    logic [8:0] rsp_q[$];
    logic [7:0] tx_log[$];
    bit         m_drain = 0, m_pass = 0, armed = 0;
    int         idle_cnt = 0, m_pkts = 0, m_errs = 0;
    int         cyc = 0, last_acc_cyc = 0, done_cyc = 0, done_cnt = 0;
    int         total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic model_finish(input bit p);
        m_pass = p;
        m_pkts++;
        if (!p) m_errs++;
        ph = M_FIN;
    endtask

    initial begin : compare
        logic [7:0] v;
        bit         par;
        forever begin
            @(negedge a_clk);
            #3;
            cyc++;
            if (armed) begin
                check("busy",      busy,                (ph != M_IDLE));
                check("done",      done,                (ph == M_FIN));
                check("m_tvalid",  axis.axis_m_tvalid,  (ph == M_SEND));
                check("m_tdata",   axis.axis_m_tdata,   (ph == M_SEND) ? tx_q[0] : 8'h00);
                check("m_tlast",   axis.axis_m_tlast,   (ph == M_SEND) && (tx_q.size() == 1));
                check("s_tready",  axis.axis_s_tready,  (ph == M_RSP));
                check("pass",      pass,                m_pass);
                check("pkt_count", pkt_count,           16'(m_pkts));
                check("err_count", err_count,           16'(m_errs));
            end
            if (axis.axis_m_tvalid === 1'b1 && axis.axis_m_tready === 1'b1)
                tx_log.push_back(axis.axis_m_tdata);
            if (axis_areset) begin
                ph = M_IDLE; m_lfsr = 8'hA5; m_pass = 0; m_pkts = 0; m_errs = 0;
                tx_q.delete(); rsp_q.delete(); armed = 1;
            end else if (armed) begin
                case (ph)
                    M_IDLE: if (start) begin
                        v = m_lfsr; par = 0;
                        for (int i = 0; i < PKT_LEN; i++) begin
                            tx_q.push_back(v);
                            par ^= ^v;
                            v = lfsr_step(v);
                        end
                        m_lfsr = v;
                        want_q.delete();
                        if (par) want_q.push_back(9'h1FF);
                        else begin
                            want_q.push_back(9'h0AB); want_q.push_back(9'h012); want_q.push_back(9'h1DE);
                        end
                        ph = M_SEND;
                    end
                    M_SEND: if (axis.axis_m_tready) begin
                        void'(tx_q.pop_front());
                        last_acc_cyc = cyc;
                        if (tx_q.size() == 0) begin
                            rsp_q = want_q; m_drain = 0; idle_cnt = 0; ph = M_RSP;
                        end
                    end
                    M_RSP: if (axis.axis_s_tvalid) begin
                        idle_cnt = 0;
                        last_acc_cyc = cyc;
                        if (m_drain) begin
                            if (axis.axis_s_tlast) model_finish(0);
                        end else if ({axis.axis_s_tlast, axis.axis_s_tdata} == rsp_q[0]) begin
                            void'(rsp_q.pop_front());
                            if (rsp_q.size() == 0) model_finish(1);
                        end else if (axis.axis_s_tlast) model_finish(0);
                        else m_drain = 1;
                    end else begin
                        idle_cnt++;
                        if (idle_cnt == TMO) model_finish(0);
                    end
                    M_FIN: begin
                        done_cyc = cyc; done_cnt++; ph = M_IDLE;
                    end
                    default: ph = M_IDLE;
                endcase
            end
        end
    end

    task automatic launch();
        @(negedge a_clk); start = 1'b1;
        @(negedge a_clk); start = 1'b0;
    endtask

    task automatic send_pkt(input int rdy_pct, input bit noisy);
        int n = 0;
        while (axis.axis_s_tready !== 1'b1 && n < 400) begin
            axis.axis_m_tready = (int'($urandom_range(0, 99)) < rdy_pct) ? 1'b1 : 1'b0;
            start = (noisy && $urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
            @(negedge a_clk);
            n++;
        end
        axis.axis_m_tready = 1'b0;
        start = 1'b0;
        check("send_reaches_recv", axis.axis_s_tready, 1'b1);
    endtask

    task automatic respond(input logic [8:0] seq[$], input int gap_pct);
        int d0 = done_cnt;
        int guard;
        bit quit = 0;
        foreach (seq[i]) begin
            if (quit) break;
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                axis.axis_s_tvalid = 1'b0;
                @(negedge a_clk);
            end
            axis.axis_s_tvalid = 1'b1;
            axis.axis_s_tdata  = seq[i][7:0];
            axis.axis_s_tlast  = seq[i][8];
            guard = 0;
            while (!quit) begin
                if (axis.axis_s_tready === 1'b1) begin
                    @(negedge a_clk);
                    break;
                end
                if (done_cnt != d0 || guard > 4 * TMO) quit = 1;
                else begin
                    @(negedge a_clk);
                    guard++;
                end
            end
        end
        axis.axis_s_tvalid = 1'b0;
        axis.axis_s_tdata  = 8'h00;
        axis.axis_s_tlast  = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 4 * TMO) begin
            @(negedge a_clk);
            n++;
        end
        check("done_seen", (done_cnt != d0), 1'b1);
        @(negedge a_clk);
    endtask

    task automatic run_txn(input int rdy_pct, input int mut, input int gap_pct);
        logic [8:0] seq[$];
        int d0, k;
        d0 = done_cnt;
        launch();
        send_pkt(rdy_pct, 1'b1);
        seq = rsp_q;
        case (mut)
            1: begin
                k = int'($urandom_range(0, seq.size() - 1));
                seq[k] = seq[k] ^ {1'b0, 8'(1 << $urandom_range(0, 7))};
            end
            2: begin
                k = int'($urandom_range(0, seq.size() - 1));
                seq[k] = seq[k] ^ 9'h100;
            end
            3: begin
                k = int'($urandom_range(1, seq.size()));
                repeat (k) void'(seq.pop_back());
            end
            default: ;
        endcase
        respond(seq, gap_pct);
        wait_done(d0);
    endtask

    initial begin : stimulus
        logic [8:0] seq[$];
        int d0, n, n0, r;
        axis.axis_m_tready = 1'b0;
        axis.axis_s_tvalid = 1'b0;
        axis.axis_s_tdata  = 8'h00;
        axis.axis_s_tlast  = 1'b0;
        repeat (3) @(negedge a_clk);
        axis_areset = 1'b0;
        @(negedge a_clk);
        check("rst_busy",   busy,               1'b0);
        check("rst_tvalid", axis.axis_m_tvalid, 1'b0);
        check("rst_tdata",  axis.axis_m_tdata,  8'h00);
        check("rst_pkts",   pkt_count,          16'd0);

        // Even packet with a correct AB,12,DE reply
        d0 = done_cnt;
        launch();
        send_pkt(100, 1'b0);
        seq = rsp_q;
        check("pkt1_bytes", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'hA54A952A);
        check("pkt1_rsp_len", seq.size(), 3);
        respond(seq, 0);
        wait_done(d0);
        check("pkt1_pass", pass, 1'b1);
        check("pkt1_pkts", pkt_count, 16'd1);
        check("pkt1_errs", err_count, 16'd0);
        check("pkt1_done_lat", done_cyc - last_acc_cyc, 1);

        // Wrong reply byte, or wrong tlast position on an odd reply, then drain
        d0 = done_cnt;
        launch();
        send_pkt(50, 1'b1);
        seq = rsp_q;
        if (seq.size() == 3) seq[1] = 9'h013;
        else begin
            seq[0] = 9'h0FF;
            seq.push_back(9'h1DE);
        end
        respond(seq, 20);
        wait_done(d0);
        check("wrong_pass", pass, 1'b0);
        check("wrong_errs", err_count, 16'd1);
        check("wrong_pkts", pkt_count, 16'd2);

        run_txn(70, 0, 20);
        check("recover_pass", pass, 1'b1);
        check("recover_errs", err_count, 16'd1);

        // Silent responder, with a start pulse landing in the done cycle
        d0 = done_cnt;
        launch();
        send_pkt(100, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 4 * TMO) begin
            @(negedge a_clk);
            n++;
        end
        if (done === 1'b1) begin
            start = 1'b1;
            @(negedge a_clk);
            start = 1'b0;
        end
        @(negedge a_clk);
        check("tmo_done_seen", (done_cnt != d0), 1'b1);
        check("tmo_done_lat", done_cyc - last_acc_cyc, 11);
        check("tmo_pass", pass, 1'b0);
        check("tmo_errs", err_count, 16'd2);
        @(negedge a_clk);
        check("fin_start_ignored", busy, 1'b0);

        // Reset during the second beat of a packet
        launch();
        axis.axis_m_tready = 1'b1;
        @(negedge a_clk);
        axis_areset = 1'b1;
        axis.axis_m_tready = 1'b0;
        @(negedge a_clk);
        axis_areset = 1'b0;
        check("mid_rst_busy",   busy,               1'b0);
        check("mid_rst_tvalid", axis.axis_m_tvalid, 1'b0);
        check("mid_rst_tdata",  axis.axis_m_tdata,  8'h00);
        check("mid_rst_pkts",   pkt_count,          16'd0);
        check("mid_rst_errs",   err_count,          16'd0);
        n0 = tx_log.size();
        d0 = done_cnt;
        launch();
        send_pkt(100, 1'b0);
        check("post_rst_byte0", tx_log[n0], 8'hA5);
        seq = rsp_q;
        respond(seq, 0);
        wait_done(d0);
        check("post_rst_pass", pass, 1'b1);
        check("post_rst_pkts", pkt_count, 16'd1);

        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 5));
            run_txn(int'($urandom_range(30, 100)), (r < 3) ? 0 : r - 2, 30);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
